// File: rtl/unsat_clause_picker_pkg.sv
// unsat_clause_picker_pkg: shared SAT clause layout, picker state encoding and LFSR polynomial
package unsat_clause_picker_pkg;
  localparam int SAT_LIT_WIDTH = 12;
  localparam int SAT_LITS = 3;
  localparam int SAT_CLAUSE_WIDTH = SAT_LITS * SAT_LIT_WIDTH;
  localparam int SAT_VAR_WIDTH = SAT_LIT_WIDTH - 1;
  localparam logic [15:0] SAT_LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_PRESENT} picker_state_t;
  typedef struct packed {
    logic neg;
    logic [SAT_VAR_WIDTH-1:0] var_idx;
  } sat_lit_t;
  function automatic sat_lit_t lit_at(input logic [SAT_CLAUSE_WIDTH-1:0] c, input int k);
    return sat_lit_t'(c[k*SAT_LIT_WIDTH +: SAT_LIT_WIDTH]);
  endfunction
  function automatic logic lit_empty(input sat_lit_t l);
    return l.var_idx == '0;
  endfunction
endpackage

// File: rtl/unsat_clause_picker_if.sv
// unsat_clause_picker_if: tree-read and selected-clause handshake bundle for the picker
interface unsat_clause_picker_if
  import unsat_clause_picker_pkg::*;
#(
  parameter int CLAUSE_WIDTH = SAT_CLAUSE_WIDTH,
  parameter int COUNT_WIDTH = 16
);
  logic start_i;
  logic fifo_empty_i;
  logic [CLAUSE_WIDTH-1:0] fifo_clause_i;
  logic fifo_rden_o;
  logic [CLAUSE_WIDTH-1:0] sel_clause_o;
  logic sel_valid_o;
  logic sel_ready_i;
  logic none_o;
  logic busy_o;
  logic [COUNT_WIDTH-1:0] unsat_count_o;
  modport master (
    input start_i, fifo_empty_i, fifo_clause_i, sel_ready_i,
    output fifo_rden_o, sel_clause_o, sel_valid_o, none_o, busy_o, unsat_count_o
  );
  modport slave (
    output start_i, fifo_empty_i, fifo_clause_i, sel_ready_i,
    input fifo_rden_o, sel_clause_o, sel_valid_o, none_o, busy_o, unsat_count_o
  );
endinterface

// File: rtl/unsat_clause_picker_lfsr_galois.sv
// lfsr_galois: free-running right-shifting Galois LFSR, shared with the flip stage for tie-breaking
module lfsr_galois
  import unsat_clause_picker_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(SAT_LFSR_TAPS)
) (
  input logic clk,
  input logic reset,
  output logic [WIDTH-1:0] q
);
  // the bit shifted out of the bottom feeds back into every tap position
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= SEED;
    else q <= (q >> 1) ^ (q[0] ? TAPS : '0);
endmodule

// File: rtl/unsat_clause_picker.sv
// unsat_clause_picker: drains the unsat-clause tree each round and offers one pseudo-randomly chosen clause
module unsat_clause_picker
  import unsat_clause_picker_pkg::*;
#(
  parameter int CLAUSE_WIDTH = SAT_CLAUSE_WIDTH,
  parameter int SKIP_WIDTH = 4,
  parameter int LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = LFSR_WIDTH'(16'hACE1),
  parameter int SETTLE_CYCLES = 4,
  parameter int COUNT_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  unsat_clause_picker_if.master bus
);
  localparam int PW = SKIP_WIDTH + 1;
  picker_state_t state;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [SKIP_WIDTH-1:0] skip;
  logic [PW-1:0] pop_idx;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [CLAUSE_WIDTH-1:0] pick;
  logic [3:0] quiet;
  logic have, rd_q, idle_tick, quiet_hit, lfsr_unused;
  lfsr_galois #(.WIDTH(LFSR_WIDTH), .SEED(LFSR_SEED), .TAPS(LFSR_WIDTH'(SAT_LFSR_TAPS))) u_lfsr (
    .clk(clk),
    .reset(reset),
    .q(lfsr)
  );
  assign lfsr_unused = ^lfsr[LFSR_WIDTH-1:SKIP_WIDTH];
  assign bus.fifo_rden_o = state == ST_DRAIN && !bus.fifo_empty_i;
  assign bus.sel_clause_o = pick;
  assign idle_tick = bus.fifo_empty_i && !rd_q;
  assign quiet_hit = idle_tick && quiet + 4'd1 == 4'(SETTLE_CYCLES);
  // round sequencing: drain with pick/count bookkeeping, then present or report an empty round
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      skip <= '0;
      pop_idx <= '0;
      cnt <= '0;
      quiet <= '0;
      have <= 1'b0;
      rd_q <= 1'b0;
      pick <= '0;
      bus.sel_valid_o <= 1'b0;
      bus.none_o <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.unsat_count_o <= '0;
    end else begin
      rd_q <= bus.fifo_rden_o;
      bus.none_o <= 1'b0;
      case (state)
        ST_IDLE: if (bus.start_i) begin
          state <= ST_DRAIN;
          bus.busy_o <= 1'b1;
          skip <= lfsr[SKIP_WIDTH-1:0];
          pop_idx <= '0;
          cnt <= '0;
          have <= 1'b0;
          quiet <= '0;
        end
        ST_DRAIN: begin
          if (rd_q) begin
            cnt <= &cnt ? cnt : cnt + COUNT_WIDTH'(1);
            pop_idx <= &pop_idx ? pop_idx : pop_idx + PW'(1);
            if (pop_idx <= {1'b0, skip}) begin
              pick <= bus.fifo_clause_i;
              have <= 1'b1;
            end
          end
          quiet <= idle_tick ? quiet + 4'd1 : '0;
          if (quiet_hit) begin
            bus.unsat_count_o <= cnt;
            state <= have ? ST_PRESENT : ST_IDLE;
            bus.sel_valid_o <= have;
            bus.busy_o <= have;
            bus.none_o <= !have;
          end
        end
        ST_PRESENT: if (bus.sel_ready_i) begin
          state <= ST_IDLE;
          bus.sel_valid_o <= 1'b0;
          bus.busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
